// File: rtl/sw_led_debounce.sv
// sw_led_debounce
// Switch-to-LED front end: per-channel 2-FF synchroniser, debounce counter,
// registered level / rise / fall outputs, a per-channel toggle register and
// a mode-selected registered LED drive (direct, toggle, blink, inverted).
// Optional feature macro: SW_LED_BLINK_EN. When it is defined, the blink
// prescaler and phase bit are built. When it is undefined, phase is a
// constant 1, so blink mode shows the debounced level just as direct mode does.

module sw_led_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] leds,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sw_led_debounce: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("sw_led_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("sw_led_debounce: BLINK_DIV must be >= 2");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] tog_q;
    logic [WIDTH-1:0] tog_d;
    logic [WIDTH-1:0] leds_q;
    logic [WIDTH-1:0] leds_d;
    logic [WIDTH-1:0] rise_now;
    logic             phase;

    // Two-stage synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES samples before it is accepted.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce counter and accepted-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
        end
    end

    // A rising transition is visible while the accepted level leads the output level.
    assign rise_now = stable_q & ~level_q;

`ifdef SW_LED_BLINK_EN
    localparam int PRE_W = $clog2(BLINK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             phase_q;
    logic             phase_d;

    // Blink prescaler: wrap at BLINK_DIV-1 and flip the shared phase bit on wrap.
    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            phase_d = ~phase_q;
        end else begin
            pre_d   = pre_q + PRE_W'(1);
            phase_d = phase_q;
        end
    end

    // Prescaler and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    assign phase = 1'b1;
`endif

    // Toggle state and LED source selection for the next edge.
    always_comb begin
        tog_d = tog_q ^ rise_now;
        case (mode)
            MODE_DIRECT: leds_d = stable_q;
            MODE_TOGGLE: leds_d = tog_q ^ rise_now;
            MODE_BLINK:  leds_d = stable_q & {WIDTH{phase}};
            MODE_INVERT: leds_d = ~stable_q;
            default:     leds_d = stable_q;
        endcase
    end

    // Registered outputs, all updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            tog_q   <= '0;
            leds_q  <= '0;
        end else begin
            level_q <= stable_q;
            rise_q  <= rise_now;
            fall_q  <= ~stable_q & level_q;
            tog_q   <= tog_d;
            leds_q  <= leds_d;
        end
    end

    assign leds     = leds_q;
    assign sw_level = level_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: tb/tb_sw_led_debounce.sv
// Self-checking bench for sw_led_debounce (WIDTH=4, DEBOUNCE_CYCLES=4, BLINK_DIV=3).
// Expected blink behaviour follows SW_LED_BLINK_EN as seen by this compile.

module tb_sw_led_debounce;

    localparam int W = 4;
    localparam int D = 4;
    localparam int B = 3;
`ifdef SW_LED_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] switches = '0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] leds;
    logic [W-1:0] sw_level;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    int checks = 0;
    int errors = 0;

    sw_led_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .BLINK_DIV(B)) dut (
        .clk(clk), .rst(rst), .switches(switches), .mode(mode),
        .leds(leds), .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (history based) ----------------
    logic [W-1:0] m_sw_hist[$];    // switch value seen at edge n
    logic [W-1:0] m_sync_hist[$];  // synchronised value present before edge n
    int           m_n;             // edges since reset release
    logic [W-1:0] m_stable, m_lvl, m_rise, m_fall, m_tog, m_leds;

    task automatic model_reset();
        m_sw_hist.delete();
        m_sync_hist.delete();
        m_n = 0;
        m_stable = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_leds = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] sync_b, rise_now, nxt;
        logic         phase_b;
        bit           all_diff;
        sync_b = (m_n >= 2) ? m_sw_hist[m_n-2] : 4'b0000;
        m_sync_hist.push_back(sync_b);
        m_sw_hist.push_back(switches);
        phase_b  = BLINK_ON ? (((m_n / B) % 2) == 1) : 1'b1;
        rise_now = m_stable & ~m_lvl;
        case (mode)
            2'd0:    m_leds = m_stable;
            2'd1:    m_leds = m_tog ^ rise_now;
            2'd2:    m_leds = m_stable & {W{phase_b}};
            default: m_leds = ~m_stable;
        endcase
        m_rise = rise_now;
        m_fall = ~m_stable & m_lvl;
        m_lvl  = m_stable;
        m_tog  = m_tog ^ rise_now;
        // A level is accepted once the last D synchronised samples all disagree with it.
        nxt = m_stable;
        for (int i = 0; i < W; i++) begin
            if (m_n >= D - 1) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (m_sync_hist[m_n-j][i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) nxt[i] = ~m_stable[i];
            end
        end
        m_stable = nxt;
        m_n++;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_leds",  {28'd0, leds},     {28'd0, m_leds});
        check("model_level", {28'd0, sw_level}, {28'd0, m_lvl});
        check("model_rise",  {28'd0, sw_rise},  {28'd0, m_rise});
        check("model_fall",  {28'd0, sw_fall},  {28'd0, m_fall});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_leds",  {28'd0, leds},     32'd0);
        check("reset_level", {28'd0, sw_level}, 32'd0);
        check("reset_rise",  {28'd0, sw_rise},  32'd0);
        check("reset_fall",  {28'd0, sw_fall},  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic [1:0]   md;
        logic [W-1:0] e_level;
        logic [W-1:0] e_rise;
        logic [W-1:0] e_fall;
        logic [W-1:0] e_leds;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int rises, falls, rise_seen;
        logic prev_led2;
        logic [W-1:0] bl[12];

        // Direct mode: 0101 pressed, then released; outputs 7 edges after each change.
        for (int i = 0; i < 17; i++) begin
            tbl[i].sw      = (i < 9) ? 4'b0101 : 4'b0000;
            tbl[i].md      = 2'b00;
            tbl[i].e_level = (i >= 6 && i < 15) ? 4'b0101 : 4'b0000;
            tbl[i].e_rise  = (i == 6)  ? 4'b0101 : 4'b0000;
            tbl[i].e_fall  = (i == 15) ? 4'b0101 : 4'b0000;
            tbl[i].e_leds  = tbl[i].e_level;
        end

        #2;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            switches = tbl[i].sw;
            mode     = tbl[i].md;
            tick();
            check("tbl_level", {28'd0, sw_level}, {28'd0, tbl[i].e_level});
            check("tbl_rise",  {28'd0, sw_rise},  {28'd0, tbl[i].e_rise});
            check("tbl_fall",  {28'd0, sw_fall},  {28'd0, tbl[i].e_fall});
            check("tbl_leds",  {28'd0, leds},     {28'd0, tbl[i].e_leds});
        end

        // Glitch rejection: a 3-cycle pulse is dropped, a 4-cycle pulse is accepted.
        do_reset();
        mode = 2'b00;
        switches = 4'b0001;
        repeat (3) tick();
        switches = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch_level", {31'd0, sw_level[0]}, 32'd0);
            check("glitch_rise",  {31'd0, sw_rise[0]},  32'd0);
            check("glitch_leds",  {31'd0, leds[0]},     32'd0);
        end
        rises = 0; falls = 0;
        switches = 4'b0001;
        repeat (4) begin
            tick();
            rises += int'(sw_rise[0]); falls += int'(sw_fall[0]);
        end
        switches = 4'b0000;
        repeat (14) begin
            tick();
            rises += int'(sw_rise[0]); falls += int'(sw_fall[0]);
        end
        check("accept4_rises", rises, 32'd1);
        check("accept4_falls", falls, 32'd1);

        // Toggle mode: two press/release cycles on bit 2.
        do_reset();
        mode = 2'b01;
        switches = 4'b0000;
        rise_seen = 0;
        prev_led2 = 1'b0;
        repeat (2) begin
            for (int ph = 0; ph < 2; ph++) begin
                switches = (ph == 0) ? 4'b0100 : 4'b0000;
                repeat (10) begin
                    tick();
                    if (sw_rise[2]) begin
                        rise_seen++;
                        check("toggle_on_rise", {31'd0, leds[2]}, (rise_seen == 1) ? 32'd1 : 32'd0);
                    end
                    if (sw_fall[2]) check("toggle_fall_hold", {31'd0, leds[2]}, {31'd0, prev_led2});
                    prev_led2 = leds[2];
                end
            end
        end
        check("toggle_rise_count", rise_seen, 32'd2);

        // Blink mode with all switches on.
        do_reset();
        mode = 2'b10;
        switches = 4'b1111;
        repeat (10) tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            bl[k] = leds;
        end
        for (int k = 0; k < 12; k++) begin
            if (BLINK_ON) begin
                check("blink_value", {31'd0, (bl[k] == 4'b0000) || (bl[k] == 4'b1111)}, 32'd1);
                if (k < 9) check("blink_period", {28'd0, bl[k+3]}, {28'd0, ~bl[k]});
            end else begin
                check("blink_off_hold", {28'd0, bl[k]}, 32'hF);
            end
        end

        // Inverted mode, then a switch to toggle mode.
        do_reset();
        mode = 2'b11;
        switches = 4'b0011;
        repeat (10) tick();
        check("invert_leds", {28'd0, leds}, 32'hC);
        mode = 2'b01;
        tick();
        check("modechg_tog", {28'd0, leds}, 32'h3);

        // Reset in the middle of a bit-1 debounce, switch held through reset.
        do_reset();
        mode = 2'b11;
        switches = 4'b0000;
        repeat (8) tick();
        switches = 4'b0010;
        repeat (4) tick();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("rst_rise1", {31'd0, sw_rise[1]}, (k == 7) ? 32'd1 : 32'd0);
        end

        // Randomised stimulus against the reference model.
        repeat (3) begin
            do_reset();
            for (int t = 0; t < 200; t++) begin
                for (int i = 0; i < W; i++) begin
                    if ($urandom_range(0, 5) == 0) switches[i] = ~switches[i];
                end
                if ($urandom_range(0, 30) == 0) mode = 2'($urandom_range(0, 3));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_led_debounce.md
# sw_led_debounce

Parametrised switch-to-LED front end for the board I/O: replaces the plain switch-to-LED wire with per-channel synchronisation, debounce, edge pulses and selectable LED modes. It sits between the raw board switch pins and the LED pins, and it also feeds debounced levels and edge pulses to downstream logic.

## Interface

- `WIDTH`, 4: number of switch/LED channels (1-32).
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a new level must persist before it is accepted (≥2).
- `BLINK_DIV`, 25000000: clock cycles per blink half-period (≥2).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `switches`  in  WIDTH  raw, asynchronous switch pins.
- `mode`  in  2  LED mode, common to all channels: 00 direct, 01 toggle, 10 blink, 11 inverted.
- `leds`  out  WIDTH  registered LED drive.
- `sw_level`  out  WIDTH  debounced switch level.
- `sw_rise`  out  WIDTH  one-cycle pulse on each debounced 0→1 transition.
- `sw_fall`  out  WIDTH  one-cycle pulse on each debounced 1→0 transition.

## Operation

- **Synchroniser:** each channel passes through a 2-FF synchroniser; `sync` is the second stage.
- **Debounce counter:** one per channel, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync == stable`, the counter is cleared to 0.
  - Otherwise, if counter == `DEBOUNCE_CYCLES-1`, then `stable <= sync` and the counter is cleared.
  - Otherwise, the counter increments.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `stable`.
- **Outputs (all registered, updated together):**
  - `sw_level <= stable`.
  - `sw_rise <= stable & ~sw_level`.
  - `sw_fall <= ~stable & sw_level`.
- **Toggle register:** per channel, `tog[i]` inverts on every cycle where `stable[i] & ~sw_level[i]`. It is maintained in every mode.
- **Blink prescaler:** counts 0..`BLINK_DIV-1` and wraps to 0. The shared `phase` bit inverts on each wrap.
- **LED select (registered), sampled every cycle:**
  - 00: `leds <= stable`
  - 01: `leds <= tog ^ rise_now`, so the LED shows the new toggle state in the same cycle as `sw_rise`.
  - 10: `leds <= stable & {WIDTH{phase}}`
  - 11: `leds <= ~stable`
- A mode change takes effect on the next clock edge. `tog` and `phase` are never cleared by a mode change.
- **Reset values:**
  - `leds`, `sw_level`, `sw_rise`, `sw_fall` = 0.
  - Synchronisers, `stable`, counters, `tog`, prescaler and `phase` = 0.
- **Reset mid-operation:** all state clears immediately. A switch held high through reset is re-accepted after the full debounce latency and produces one `sw_rise`.

## Timing

- `switches[i]` changes and is stable before edge 0:
  - `sync` updates at edge 2.
  - `stable` updates at edge 1+`DEBOUNCE_CYCLES`+1, i.e. edge `DEBOUNCE_CYCLES`+2.
  - `sw_level`, `sw_rise`/`sw_fall` and `leds` update at edge `DEBOUNCE_CYCLES`+3.
- Latency from pin to outputs is `DEBOUNCE_CYCLES`+3 cycles. Pulses are exactly one cycle wide.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Blink period is 2×`BLINK_DIV` cycles. `phase` first goes high at edge `BLINK_DIV` after reset release. The corresponding `leds` change occurs one edge later.
- Throughput: the maximum accepted transition rate per channel is one per `DEBOUNCE_CYCLES` cycles.

## Configuration

- `SW_LED_BLINK_EN` defined:
  - The prescaler and `phase` are built.
  - Mode 10 blinks as specified.
- `SW_LED_BLINK_EN` undefined:
  - No prescaler logic is built and `phase` is constant 1.
  - Mode 10 therefore behaves exactly as mode 00.
  - `BLINK_DIV` is ignored.

## Test plan

Bench parameters: `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `BLINK_DIV`=3, `SW_LED_BLINK_EN` defined unless stated.

- **Direct mode:** reset, `mode`=00, `switches`=4'b0101 held → `leds`=`sw_level`=4'b0101 exactly 7 edges after the change. `sw_rise`=4'b0101 for 1 cycle only; `sw_fall` stays 0.
- **Glitch rejection:** bit0 high for 3 cycles then low → `sw_level`, `leds` and `sw_rise` stay 0. A 4-cycle high is accepted.
- **Toggle mode:** `mode`=01, press/release bit2 twice (each level held 10 cycles) → `leds[2]` goes 1 on the first `sw_rise`, 0 on the second. Releases do not change `leds[2]`.
- **Blink mode:** `mode`=10, `switches`=4'b1111 debounced → `leds` alternates 4'b0000/4'b1111 every 3 cycles. Re-run without `SW_LED_BLINK_EN` → `leds` holds 4'b1111.
- **Inverted mode and mode change:** debounced 4'b0011 in `mode`=11 → `leds`=4'b1100. Then switch to `mode`=01 → `tog` value appears on the next edge.
- **Reset mid-count:** assert `rst` with a bit1 transition 2 cycles into debounce → all outputs 0 immediately. After release with bit1 still high, `sw_rise[1]` pulses once, 7 edges later.
